// File: rtl/host_dpi_pkg.sv
// Shared constants for the host DPI CSR responder.
//   OPC_RD / OPC_WR   request opcode encodings
//   state_t           responder FSM states
//   REG_CTRL / REG_CYCLES  fixed CSR indices; CTRL_* bit positions in CTRL
package host_dpi_pkg;

   localparam logic OPC_RD = 1'b0;
   localparam logic OPC_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DEQ  = 2'd1,
      EXEC = 2'd2
   } state_t;

   localparam int REG_CTRL    = 0;
   localparam int REG_CYCLES  = 1;

   localparam int CTRL_LAUNCH = 0;
   localparam int CTRL_DONE   = 1;

endpackage

// File: rtl/host_dpi_csr_responder.sv
// Device-side responder for the host DPI request/response channel.
// Each request takes three cycles: IDLE samples it, DEQ pulses dpi_req_deq,
// EXEC applies the write or returns read data. Also owns accelerator
// launch/finish handshake and a saturating busy-cycle counter.
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   dpi_req_valid/opcode/addr/value   host request (opcode 1=write)
//   dpi_req_deq           one-cycle pulse, request consumed
//   dpi_resp_valid/bits   one-cycle read response (bits 0 otherwise)
//   launch                one-cycle start pulse to the core
//   finish                core done pulse
//   vals                  general regs 2..NUM_REGS-1, reg2 in LSBs
module host_dpi_csr_responder
   import host_dpi_pkg::*;
#(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int NUM_REGS  = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              dpi_req_valid,
   input  logic                              dpi_req_opcode,
   input  logic [ADDR_BITS-1:0]              dpi_req_addr,
   input  logic [DATA_BITS-1:0]              dpi_req_value,
   output logic                              dpi_req_deq,
   output logic                              dpi_resp_valid,
   output logic [DATA_BITS-1:0]              dpi_resp_bits,
   output logic                              launch,
   input  logic                              finish,
   output logic [(NUM_REGS-2)*DATA_BITS-1:0] vals
);

   localparam int IDX_W = $clog2(NUM_REGS);

   state_t                              state, next_state;
   logic                                opc_q;
   logic [ADDR_BITS-1:2]                addr_q;
   logic [DATA_BITS-1:0]                value_q;
   logic                                busy_q, done_q, launch_q;
   logic [DATA_BITS-1:0]                cycles_q;
   logic [NUM_REGS-3:0][DATA_BITS-1:0]  gen_q;

   logic [IDX_W-1:0]                    idx;
   logic                                out_of_range;
   logic                                wr_fire;
   logic [DATA_BITS-1:0]                rd_data;
   logic                                addr_unused;

   // Byte offset within a word carries no information here.
   assign addr_unused  = ^dpi_req_addr[1:0];

   assign idx          = addr_q[IDX_W+1:2];
   assign out_of_range = |addr_q[ADDR_BITS-1:IDX_W+2];
   assign wr_fire      = (state == EXEC) && (opc_q == OPC_WR) && !out_of_range;
   assign launch       = launch_q;
   assign vals         = gen_q;

   // CSR read mux; CTRL.launch always reads back as 0.
   always_comb begin
      rd_data = '0;
      if (!out_of_range) begin
         if (idx == IDX_W'(REG_CTRL))
            rd_data[CTRL_DONE] = done_q;
         else if (idx == IDX_W'(REG_CYCLES))
            rd_data = cycles_q;
         for (int r = 2; r < NUM_REGS; r++)
            if (idx == IDX_W'(r)) rd_data = gen_q[r-2];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Outputs are masked during reset so a transaction in flight is dropped
   // without a stray deq or response in the reset cycle itself.
   always_comb begin
      next_state     = state;
      dpi_req_deq    = 1'b0;
      dpi_resp_valid = 1'b0;
      dpi_resp_bits  = '0;
      case (state)
         IDLE: if (dpi_req_valid) next_state = DEQ;
         DEQ: begin
            dpi_req_deq = !reset;
            next_state  = EXEC;
         end
         EXEC: begin
            if (opc_q == OPC_RD && !reset) begin
               dpi_resp_valid = 1'b1;
               dpi_resp_bits  = rd_data;
            end
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         opc_q    <= OPC_RD;
         addr_q   <= '0;
         value_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         launch_q <= 1'b0;
         cycles_q <= '0;
         gen_q    <= '0;
      end else begin
         if (state == IDLE && dpi_req_valid) begin
            opc_q   <= dpi_req_opcode;
            addr_q  <= dpi_req_addr[ADDR_BITS-1:2];
            value_q <= dpi_req_value;
         end

         launch_q <= 1'b0;

         if (busy_q) begin
            if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
            if (finish) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end

         // Placed after the finish handling so a same-cycle launch wins.
         // CYCLES is never a host write target, so counter updates always stick.
         if (wr_fire) begin
            if (idx == IDX_W'(REG_CTRL) && value_q[CTRL_LAUNCH]) begin
               launch_q <= 1'b1;
               busy_q   <= 1'b1;
               done_q   <= 1'b0;
               cycles_q <= '0;
            end
            for (int r = 2; r < NUM_REGS; r++)
               if (idx == IDX_W'(r)) gen_q[r-2] <= value_q;
         end
      end
   end

endmodule

// File: tb/tb_host_dpi_csr_responder.sv
// Directed bench for host_dpi_csr_responder: a vector table of single
// requests plus hand-written sequences for held-valid, launch/finish,
// launch-vs-finish collision and mid-transaction reset.
module tb_host_dpi_csr_responder;

   logic         clock = 1'b0;
   logic         reset;
   logic         dpi_req_valid;
   logic         dpi_req_opcode;
   logic [31:0]  dpi_req_addr;
   logic [31:0]  dpi_req_value;
   logic         dpi_req_deq;
   logic         dpi_resp_valid;
   logic [31:0]  dpi_resp_bits;
   logic         launch;
   logic         finish;
   logic [191:0] vals;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   host_dpi_csr_responder #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_REGS(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .dpi_req_valid  (dpi_req_valid),
      .dpi_req_opcode (dpi_req_opcode),
      .dpi_req_addr   (dpi_req_addr),
      .dpi_req_value  (dpi_req_value),
      .dpi_req_deq    (dpi_req_deq),
      .dpi_resp_valid (dpi_resp_valid),
      .dpi_resp_bits  (dpi_resp_bits),
      .launch         (launch),
      .finish         (finish),
      .vals           (vals)
   );

   typedef struct {
      string       name;
      logic        opc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rv;
      logic [31:0] exp_rb;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Starts and ends on a falling edge with the DUT in IDLE; takes 3 cycles.
   task automatic do_req(input logic opc, input logic [31:0] addr, input logic [31:0] val,
                         output logic deq1, output logic deq2,
                         output logic rv, output logic [31:0] rb);
      dpi_req_valid  = 1'b1;
      dpi_req_opcode = opc;
      dpi_req_addr   = addr;
      dpi_req_value  = val;
      @(negedge clock);
      deq1 = dpi_req_deq;
      dpi_req_valid = 1'b0;
      @(negedge clock);
      deq2 = dpi_req_deq;
      rv   = dpi_resp_valid;
      rb   = dpi_resp_bits;
      @(negedge clock);
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
      logic d1, d2, rv;
      logic [31:0] rb;
      do_req(1'b0, addr, 32'h0, d1, d2, rv, rb);
      chk({nm, "_rv"}, 64'(rv), 64'd1);
      chk(nm, 64'(rb), 64'(exp));
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] val);
      logic d1, d2, rv;
      logic [31:0] rb;
      do_req(1'b1, addr, val, d1, d2, rv, rb);
      chk("wr_deq", 64'(d1), 64'd1);
   endtask

   vec_t vecs[14];

   initial begin
      logic d1, d2, rv;
      logic [31:0] rb;

      vecs[0]  = '{"w_reg2",      1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{"r_reg2",      1'b0, 32'h08, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[2]  = '{"w_reg7",      1'b1, 32'h1C, 32'h0BADF00D, 1'b0, 32'h0};
      vecs[3]  = '{"r_reg7",      1'b0, 32'h1C, 32'h0,        1'b1, 32'h0BADF00D};
      vecs[4]  = '{"w_oor40",     1'b1, 32'h40, 32'h00000055, 1'b0, 32'h0};
      vecs[5]  = '{"r_oor40",     1'b0, 32'h40, 32'h0,        1'b1, 32'h0};
      vecs[6]  = '{"r_byteoff",   1'b0, 32'h0B, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[7]  = '{"w_alias28",   1'b1, 32'h28, 32'h00000077, 1'b0, 32'h0};
      vecs[8]  = '{"r_reg2_keep", 1'b0, 32'h08, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[9]  = '{"w_cycles",    1'b1, 32'h04, 32'h00001234, 1'b0, 32'h0};
      vecs[10] = '{"r_cycles",    1'b0, 32'h04, 32'h0,        1'b1, 32'h0};
      vecs[11] = '{"r_ctrl",      1'b0, 32'h00, 32'h0,        1'b1, 32'h0};
      vecs[12] = '{"w_ctrl0",     1'b1, 32'h00, 32'hFFFFFFFE, 1'b0, 32'h0};
      vecs[13] = '{"r_ctrl2",     1'b0, 32'h00, 32'h0,        1'b1, 32'h0};

      reset = 1'b1; dpi_req_valid = 1'b0; dpi_req_opcode = 1'b0;
      dpi_req_addr = '0; dpi_req_value = '0; finish = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_deq", 64'(dpi_req_deq), 64'd0);
      chk("rst_rv", 64'(dpi_resp_valid), 64'd0);
      chk("rst_rb", 64'(dpi_resp_bits), 64'd0);
      chk("rst_launch", 64'(launch), 64'd0);
      chk("rst_vals", 64'(|vals), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Vector table
      foreach (vecs[i]) begin
         do_req(vecs[i].opc, vecs[i].addr, vecs[i].wdata, d1, d2, rv, rb);
         chk({vecs[i].name, "_deq"}, 64'({d1, d2}), 64'b10);
         chk({vecs[i].name, "_rv"}, 64'(rv), 64'(vecs[i].exp_rv));
         chk({vecs[i].name, "_rb"}, 64'(rb), 64'(vecs[i].exp_rb));
         chk("no_launch", 64'(launch), 64'd0);
      end
      chk("vals_reg2", 64'(vals[31:0]), 64'hDEADBEEF);
      chk("vals_reg7", 64'(vals[191:160]), 64'h0BADF00D);
      chk("vals_mid", 64'(|vals[159:32]), 64'd0);

      // Valid held through DEQ/EXEC: one deq, next request 3 cycles later
      dpi_req_valid = 1'b1; dpi_req_opcode = 1'b1;
      dpi_req_addr = 32'h0C; dpi_req_value = 32'h11;
      @(negedge clock); chk("hold_deq_t1", 64'(dpi_req_deq), 64'd1);
      @(negedge clock); chk("hold_deq_t2", 64'(dpi_req_deq), 64'd0);
      @(negedge clock); chk("hold_deq_t3", 64'(dpi_req_deq), 64'd0);
      chk("hold_first_wr", 64'(vals[63:32]), 64'h11);
      dpi_req_value = 32'h22;
      @(negedge clock); chk("hold_deq_t4", 64'(dpi_req_deq), 64'd1);
      dpi_req_valid = 1'b0;
      @(negedge clock); @(negedge clock);
      rd_chk("hold_second", 32'h0C, 32'h22);

      // Launch, finish 10 cycles later
      wr(32'h00, 32'h1);
      chk("launch_pulse", 64'(launch), 64'd1);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         if (i == 1) chk("launch_end", 64'(launch), 64'd0);
      end
      finish = 1'b1;
      @(negedge clock);
      finish = 1'b0;
      rd_chk("ctrl_done", 32'h00, 32'h2);
      rd_chk("cycles10", 32'h04, 32'd10);

      // Launch while busy with finish in the same cycle: launch wins
      wr(32'h00, 32'h1);
      dpi_req_valid = 1'b1; dpi_req_opcode = 1'b1;
      dpi_req_addr = 32'h00; dpi_req_value = 32'h1;
      @(negedge clock); dpi_req_valid = 1'b0;
      @(negedge clock); finish = 1'b1;
      @(negedge clock); finish = 1'b0;
      chk("relaunch_pulse", 64'(launch), 64'd1);
      rd_chk("collide_ctrl", 32'h00, 32'h0);
      rd_chk("collide_cycles", 32'h04, 32'd5);
      finish = 1'b1;
      @(negedge clock);
      finish = 1'b0;
      rd_chk("collide_done", 32'h00, 32'h2);
      wr(32'h04, 32'h1234);
      rd_chk("cycles_ro", 32'h04, 32'd7);

      // Reset during DEQ drops the transaction
      wr(32'h08, 32'hCAFE0001);
      dpi_req_valid = 1'b1; dpi_req_opcode = 1'b0; dpi_req_addr = 32'h08;
      @(negedge clock);
      chk("rst6_deq_pre", 64'(dpi_req_deq), 64'd1);
      reset = 1'b1; dpi_req_valid = 1'b0;
      #1 chk("rst6_deq_mask", 64'(dpi_req_deq), 64'd0);
      @(negedge clock);
      chk("rst6_rv_a", 64'(dpi_resp_valid), 64'd0);
      chk("rst6_vals", 64'(|vals), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("rst6_rv_b", 64'(dpi_resp_valid), 64'd0);
      chk("rst6_deq_b", 64'(dpi_req_deq), 64'd0);
      rd_chk("rst6_reg2", 32'h08, 32'h0);
      rd_chk("rst6_ctrl", 32'h00, 32'h0);
      wr(32'h10, 32'hA5);
      rd_chk("rst6_after", 32'h10, 32'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
